// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: default operand width and FSM encoding.
package divider_pkg;

  localparam int unsigned DefaultN = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in one dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] rem,
  input  logic         in_bit,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_next,
  output logic         qbit
);

  logic [N:0] t;

  always_comb begin
    t    = {rem, in_bit};
    qbit = (t >= {1'b0, divisor});
    // The difference is below divisor, so the low N bits carry the whole result.
    rem_next = qbit ? (t[N-1:0] - divisor) : t[N-1:0];
  end

endmodule

// File: rtl/divider_16by8.sv
// Sequential 2N-by-N unsigned restoring divider with valid/ready handshakes on both sides.
module divider_16by8
  import divider_pkg::*;
#(
  parameter int unsigned N = DefaultN
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           dbz,
  output logic           ovf
);

  localparam int unsigned CntW = $clog2(N + 1);

  state_e          state_q, state_d;
  logic [N-1:0]    rem_q, rem_d;
  logic [N-1:0]    shift_q, shift_d;
  logic [N-1:0]    dvsr_q, dvsr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    quo_q, quo_d;
  logic [N-1:0]    rmd_q, rmd_d;
  logic            dbz_q, dbz_d;
  logic            ovf_q, ovf_d;

  logic [N-1:0]    step_rem;
  logic            step_qbit;

  div_step #(
    .N(N)
  ) u_step (
    .rem      (rem_q),
    .in_bit   (shift_q[N-1]),
    .divisor  (dvsr_q),
    .rem_next (step_rem),
    .qbit     (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    shift_d = shift_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          dvsr_d = divisor;
          if (divisor == '0) begin
            state_d = StDone;
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            quo_d   = '1;
            rmd_d   = dividend[N-1:0];
          end else if (dividend[2*N-1:N] >= divisor) begin
            // Quotient would need more than N bits.
            state_d = StDone;
            dbz_d   = 1'b0;
            ovf_d   = 1'b1;
            quo_d   = '1;
            rmd_d   = '1;
          end else begin
            state_d = StRun;
            rem_d   = dividend[2*N-1:N];
            shift_d = dividend[N-1:0];
            cnt_d   = '0;
          end
        end
      end
      StRun: begin
        rem_d   = step_rem;
        shift_d = {shift_q[N-2:0], step_qbit};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntW'(N - 1)) begin
          state_d = StDone;
          quo_d   = {shift_q[N-2:0], step_qbit};
          rmd_d   = step_rem;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      shift_q <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      shift_q <= shift_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_divider_16by8.sv
// Directed and randomised checks of divider_16by8 at the default width.
module tb_divider_16by8;

  localparam int N = 8;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           dbz;
  logic           ovf;

  int n_checks = 0;
  int n_fail   = 0;

  divider_16by8 #(
    .N(N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request for a single edge; caller guarantees the block is idle.
  task automatic send(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs);
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Edges after the current sample point until out_valid is seen; -1 on timeout.
  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 60) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!out_valid) edges = -1;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_checks++;
    if ({in_ready, out_valid, quotient, remainder, dbz, ovf} !== {1'b1, 1'b0, 8'h00, 8'h00, 2'b00})
      begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b q=%h r=%h dbz=%b ovf=%b, want 1 0 00 00 0 0",
               in_ready, out_valid, quotient, remainder, dbz, ovf);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_normal();
    int lat;
    send(16'h3039, 8'h7B);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL run_not_ready: got %b want 0", in_ready);
    end
    wait_valid(lat);
    n_checks++;
    if (lat !== N) begin
      n_fail++;
      $display("FAIL normal_latency: got %0d edges want %0d", lat, N);
    end
    n_checks++;
    if ({quotient, remainder, dbz, ovf} !== {8'h64, 8'h2D, 2'b00}) begin
      n_fail++;
      $display("FAIL normal_result: got q=%h r=%h dbz=%b ovf=%b want 64 2d 0 0",
               quotient, remainder, dbz, ovf);
    end
    pop();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL normal_release: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_dbz();
    int lat;
    send(16'h1234, 8'h00);
    wait_valid(lat);
    n_checks++;
    if (lat !== 0) begin
      n_fail++;
      $display("FAIL dbz_latency: got %0d extra edges want 0", lat);
    end
    n_checks++;
    if ({quotient, remainder, dbz, ovf} !== {8'hFF, 8'h34, 2'b10}) begin
      n_fail++;
      $display("FAIL dbz_result: got q=%h r=%h dbz=%b ovf=%b want ff 34 1 0",
               quotient, remainder, dbz, ovf);
    end
    pop();
  endtask

  task automatic test_ovf();
    int lat;
    send(16'h8000, 8'h40);
    wait_valid(lat);
    n_checks++;
    if (lat !== 0) begin
      n_fail++;
      $display("FAIL ovf_latency: got %0d extra edges want 0", lat);
    end
    n_checks++;
    if ({quotient, remainder, dbz, ovf} !== {8'hFF, 8'hFF, 2'b01}) begin
      n_fail++;
      $display("FAIL ovf_result: got q=%h r=%h dbz=%b ovf=%b want ff ff 0 1",
               quotient, remainder, dbz, ovf);
    end
    pop();
    send(16'hFEFF, 8'hFF);
    wait_valid(lat);
    n_checks++;
    if (lat !== N) begin
      n_fail++;
      $display("FAIL boundary_latency: got %0d edges want %0d", lat, N);
    end
    n_checks++;
    if ({quotient, remainder, dbz, ovf} !== {8'hFF, 8'hFE, 2'b00}) begin
      n_fail++;
      $display("FAIL boundary_result: got q=%h r=%h dbz=%b ovf=%b want ff fe 0 0",
               quotient, remainder, dbz, ovf);
    end
    pop();
  endtask

  task automatic test_backpressure();
    int lat;
    logic bad;
    send(16'h3039, 8'h7B);
    // Stray request while busy must be ignored.
    dividend = 16'h0100;
    divisor  = 8'h02;
    in_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (in_ready !== 1'b0) bad = 1'b1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL bp_run_ready: got in_ready=1 during RUN want 0");
    end
    wait_valid(lat);
    in_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if ({out_valid, in_ready, quotient, remainder, dbz, ovf} !== {2'b10, 8'h64, 8'h2D, 2'b00})
        bad = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL bp_hold: got vld=%b rdy=%b q=%h r=%h want 1 0 64 2d (held)",
               out_valid, in_ready, quotient, remainder);
    end
    pop();
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL bp_ignored: got vld=%b rdy=%b want 0 1 (no second result)",
               out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midrun();
    int lat;
    send(16'h3039, 8'h7B);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, in_ready, quotient, remainder} !== {2'b01, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL midrun_reset: got vld=%b rdy=%b q=%h r=%h want 0 1 00 00",
               out_valid, in_ready, quotient, remainder);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(16'h00FF, 8'h10);
    wait_valid(lat);
    n_checks++;
    if ({lat, quotient, remainder, dbz, ovf} !== {N, 8'h0F, 8'h0F, 2'b00}) begin
      n_fail++;
      $display("FAIL post_reset_result: got lat=%0d q=%h r=%h dbz=%b ovf=%b want %0d 0f 0f 0 0",
               lat, quotient, remainder, dbz, ovf, N);
    end
    pop();
  endtask

  task automatic test_random();
    int lat;
    int unsigned dvs, hi, lo, dvd, exp_q, exp_r;
    logic rdy;
    for (int k = 0; k < 1000; k++) begin
      dvs = $urandom_range(255, 1);
      hi  = $urandom_range(dvs - 1, 0);
      lo  = $urandom_range(255, 0);
      dvd = (hi << 8) | lo;
      exp_q = dvd / dvs;
      exp_r = dvd % dvs;
      send(dvd[15:0], dvs[7:0]);
      wait_valid(lat);
      n_checks++;
      if ({lat, quotient, remainder, dbz, ovf} !== {N, exp_q[7:0], exp_r[7:0], 2'b00}) begin
        n_fail++;
        $display("FAIL random_%0d %h/%h: got lat=%0d q=%h r=%h dbz=%b ovf=%b want %0d %h %h 0 0",
                 k, dvd[15:0], dvs[7:0], lat, quotient, remainder, dbz, ovf, N,
                 exp_q[7:0], exp_r[7:0]);
      end
      rdy = 1'b0;
      for (int c = 0; c < 40 && !rdy; c++) begin
        rdy = 1'($urandom_range(1, 0));
        out_ready = rdy;
        @(posedge clk);
        #1;
      end
      out_ready = 1'b0;
      if (!rdy) pop();
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    test_reset();
    test_normal();
    test_dbz();
    test_ovf();
    test_backpressure();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
